// File: rtl/mips_mem_pkg.sv
// Shared types for the MEM-stage store path: store size encoding, buffer entry, alignment check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package mips_mem_pkg;

    localparam int SB_AW = 32;
    localparam int SB_DW = 32;

    // Same encoding as the pipeline's memwrite field.
    typedef enum logic [1:0] {
        MEM_NONE = 2'b00,
        MEM_BYTE = 2'b01,
        MEM_HALF = 2'b10,
        MEM_WORD = 2'b11
    } mem_size_t;

    typedef struct packed {
        mem_size_t         size;
        logic [SB_AW-1:0]  addr;
        logic [SB_DW-1:0]  data;
    } sb_entry_t;

    // Halfwords need an even address, words a 4-byte aligned one; bytes always fit.
    function automatic logic is_aligned(input mem_size_t size, input logic [1:0] lo);
        case (size)
            MEM_HALF: return lo[0] == 1'b0;
            MEM_WORD: return lo == 2'b00;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of the store offer, memory drain port and load-check signals around the store buffer.
// Latency: n/a (wiring only).
// Backpressure: stall toward the pipeline, mem_ready from memory.
interface store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [1:0]    st_size;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          stall;
    logic          misalign;

    logic [1:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;

    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic          ld_hazard;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    // Pipeline / memory side.
    modport master (
        output st_size, st_addr, st_data, mem_ready, ld_req, ld_addr,
        input  stall, misalign, mem_we, mem_addr, mem_wdata, ld_hazard, fwd_hit, fwd_data
    );

    // Store buffer side.
    modport slave (
        input  st_size, st_addr, st_data, mem_ready, ld_req, ld_addr,
        output stall, misalign, mem_we, mem_addr, mem_wdata, ld_hazard, fwd_hit, fwd_data
    );
endinterface

// File: rtl/store_buffer_match.sv
// Word-address compare of a load against every valid entry, plus youngest-match select.
// Latency: combinational.
// Backpressure: none.
module store_buffer_match
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32
) (
    input  sb_entry_t                ent [DEPTH],
    input  logic [DEPTH-1:0]         valid,
    input  logic [$clog2(DEPTH)-1:0] tail,
    input  logic [AW-3:0]            ld_word,
    output logic [DEPTH-1:0]         hit,
    output mem_size_t                young_size,
    output logic [SB_DW-1:0]         young_data
);
    localparam int PW = $clog2(DEPTH);

    logic          unused_lo;
    logic [PW-1:0] idx;

    // Per-entry word-address match; byte offset within the word is ignored.
    always_comb begin
        hit       = '0;
        unused_lo = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hit[i]    = valid[i] && (ent[i].addr[AW-1:2] == ld_word);
            unused_lo = unused_lo ^ (^ent[i].addr[1:0]);
        end
    end

    // Walk from oldest (tail - DEPTH) to youngest (tail - 1); the last hit seen wins.
    always_comb begin
        young_size = MEM_NONE;
        young_data = '0;
        idx        = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            idx = tail - PW'(k);
            if (hit[idx]) begin
                young_size = ent[idx].size;
                young_data = ent[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between MEM stage and data memory; flags loads that hit pending stores (STORE_BUF_FWD_EN adds word forwarding).
// Latency: a store offered to an empty buffer is on mem_* the next cycle; one drain per cycle with mem_ready high.
// Backpressure: stall only when full with an aligned offer and no drain that cycle; mem_* hold while mem_ready is low.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    store_buffer_if.slave              bus,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    sb_entry_t        ent [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    off;

    mem_size_t        st_size;
    logic             offer;
    logic             aligned;
    logic             full;
    logic             drain;
    logic             enq;

    logic [DEPTH-1:0] hit;
    logic             any_hit;
    mem_size_t        young_size;
    logic [SB_DW-1:0] young_data;
    logic             unused_ld;

    assign st_size = mem_size_t'(bus.st_size);
    assign offer   = (st_size != MEM_NONE);
    assign aligned = offer && is_aligned(st_size, bus.st_addr[1:0]);

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign count = cnt;

    // Head entry is presented directly; all zero when nothing is pending.
    assign bus.mem_we    = empty ? 2'b00 : ent[head].size;
    assign bus.mem_addr  = empty ? '0 : ent[head].addr[AW-1:0];
    assign bus.mem_wdata = empty ? '0 : ent[head].data[DW-1:0];

    assign drain        = !empty && bus.mem_ready;
    assign enq          = aligned && (!full || drain);
    assign bus.stall    = full && aligned && !drain;
    assign bus.misalign = offer && !aligned;

    // Entry i is occupied when its distance from head is below the count.
    always_comb begin
        valid = '0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off      = PW'(i) - head;
            valid[i] = CW'(off) < cnt;
        end
    end

    // FIFO state: write at tail, retire at head, count tracks the net change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            if (enq) begin
                ent[tail] <= '{size: st_size, addr: SB_AW'(bus.st_addr), data: SB_DW'(bus.st_data)};
                tail      <= tail + 1'b1;
            end
            if (drain) begin
                head <= head + 1'b1;
            end
            if (enq && !drain) begin
                cnt <= cnt + 1'b1;
            end else if (!enq && drain) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_match (
        .ent        (ent),
        .valid      (valid),
        .tail       (tail),
        .ld_word    (bus.ld_addr[AW-1:2]),
        .hit        (hit),
        .young_size (young_size),
        .young_data (young_data)
    );

    assign any_hit   = |hit;
    assign unused_ld = ^bus.ld_addr[1:0];

`ifdef STORE_BUF_FWD_EN
    // Only a full-word youngest match can supply the whole load word.
    assign bus.fwd_hit  = bus.ld_req && any_hit && (young_size == MEM_WORD);
    assign bus.fwd_data = bus.fwd_hit ? young_data[DW-1:0] : '0;
`else
    logic unused_fwd;
    assign bus.fwd_hit  = 1'b0;
    assign bus.fwd_data = '0;
    assign unused_fwd   = ^{young_size, young_data};
`endif

    assign bus.ld_hazard = bus.ld_req && any_hit && !bus.fwd_hit;

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: scoreboard of enqueued stores checked at each drain, plus per-feature checks.
// Latency: n/a.
// Backpressure: mem_ready driven by the bench to exercise full/stall.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = $clog2(DEPTH+1);

    typedef struct {
        logic [1:0]  we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    localparam logic [1:0]  MS_SZ   [6] = '{2'b10, 2'b11, 2'b01, 2'b10, 2'b11, 2'b10};
    localparam logic [31:0] MS_ADDR [6] = '{32'h41, 32'h102, 32'h43, 32'h46, 32'h48, 32'h4B};
    localparam logic        MS_EXP  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          empty;
    logic [CW-1:0] count;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    store_buffer_if #(.AW(AW), .DW(DW)) bus();

    store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .empty (empty),
        .count (count)
    );

    always #5 clk = ~clk;

    function automatic bit tb_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'b10) return a[0] == 1'b0;
        if (sz == 2'b11) return a[1:0] == 2'b00;
        return 1'b1;
    endfunction

    task automatic idle();
        bus.st_size = 2'b00;
        bus.ld_req  = 1'b0;
    endtask

    task automatic put(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        bus.st_size = sz;
        bus.st_addr = a;
        bus.st_data = d;
    endtask

    // One clock: check head/count against the model, retire on drain, record accepted store.
    task automatic step();
        int   n;
        bit   drn;
        exp_t e;
        @(negedge clk);
        n = sb.size();
        checks++;
        if (count !== CW'(n)) begin
            errors++;
            $display("FAIL count: got %0d expected %0d", count, n);
        end
        drn = bus.mem_ready && (n > 0);
        if (n > 0) begin
            e = sb[0];
            checks++;
            if (bus.mem_we !== e.we || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                errors++;
                $display("FAIL head: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                         bus.mem_we, bus.mem_addr, bus.mem_wdata, e.we, e.addr, e.data);
            end
            if (drn) void'(sb.pop_front());
        end else begin
            checks++;
            if (bus.mem_we !== 2'b00) begin
                errors++;
                $display("FAIL idle_we: got %b expected 00", bus.mem_we);
            end
        end
        if (bus.st_size != 2'b00 && tb_aligned(bus.st_size, bus.st_addr) && (n < DEPTH || drn))
            sb.push_back('{we: bus.st_size, addr: bus.st_addr, data: bus.st_data});
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        idle();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4 * DEPTH && sb.size() > 0; i++) step();
        step();
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle();
        bus.mem_ready = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.ld_addr   = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 0)          begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (bus.mem_we !== 2'b00) begin errors++; $display("FAIL reset_we: got %b expected 00", bus.mem_we); end
        checks++; if (bus.mem_addr !== 0)   begin errors++; $display("FAIL reset_addr: got %h expected 0", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 0)  begin errors++; $display("FAIL reset_wdata: got %h expected 0", bus.mem_wdata); end
        checks++; if (bus.stall !== 1'b0 || bus.misalign !== 1'b0)
            begin errors++; $display("FAIL reset_stall: got stall=%b misalign=%b expected 0 0", bus.stall, bus.misalign); end
        checks++; if (bus.ld_hazard !== 1'b0 || bus.fwd_hit !== 1'b0 || bus.fwd_data !== 0)
            begin errors++; $display("FAIL reset_ld: got hz=%b hit=%b data=%h expected 0 0 0", bus.ld_hazard, bus.fwd_hit, bus.fwd_data); end
        reset = 1'b1;
    endtask

    task automatic test_latency();
        bus.mem_ready = 1'b1;
        put(2'b11, 32'd88, 32'd0);
        step();
        idle();
        #1;
        checks++;
        if (bus.mem_we !== 2'b11 || bus.mem_addr !== 32'd88 || bus.mem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL latency: got we=%b addr=%0d data=%h expected 11 88 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        step();
        checks++;
        if (empty !== 1'b1) begin errors++; $display("FAIL latency_empty: got %b expected 1", empty); end
    endtask

    task automatic test_full_stall();
        idle();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            put(2'b11, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i));
            #1;
            checks++;
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL fill_stall: got %b expected 0 at %0d", bus.stall, i); end
            step();
        end
        put(2'b11, 32'h1010, 32'hA4);
        #1;
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %b expected 1", bus.stall); end
        step();
        checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL full_hold: got %b expected 1", bus.stall); end
        bus.mem_ready = 1'b1;
        #1;
        checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL full_release: got %b expected 0", bus.stall); end
        step();
        idle();
        checks++; if (count !== CW'(DEPTH)) begin errors++; $display("FAIL full_count: got %0d expected %0d", count, DEPTH); end
        drain_all();
    endtask

    task automatic test_misalign();
        idle();
        bus.mem_ready = 1'b0;
        put(2'b11, 32'h40, 32'h11);
        step();
        for (int i = 0; i < 6; i++) begin
            put(MS_SZ[i], MS_ADDR[i], 32'hBEEF0000 + 32'(i));
            #1;
            checks++;
            if (bus.misalign !== MS_EXP[i] || bus.stall !== 1'b0) begin
                errors++;
                $display("FAIL misalign_%0d: got misalign=%b stall=%b expected %b 0", i, bus.misalign, bus.stall, MS_EXP[i]);
            end
            step();
            idle();
            #1;
            checks++;
            if (bus.misalign !== 1'b0) begin errors++; $display("FAIL misalign_pulse_%0d: got %b expected 0", i, bus.misalign); end
        end
        drain_all();
    endtask

    task automatic test_forward();
        logic        exp_hit;
        logic        exp_hz;
        logic [31:0] exp_fd;
        idle();
        bus.mem_ready = 1'b0;
        put(2'b11, 32'h100, 32'h12345678);
        step();
        idle();
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h102;
        #1;
`ifdef STORE_BUF_FWD_EN
        exp_hit = 1'b1; exp_fd = 32'h12345678; exp_hz = 1'b0;
`else
        exp_hit = 1'b0; exp_fd = 32'h0;        exp_hz = 1'b1;
`endif
        checks++;
        if (bus.fwd_hit !== exp_hit || bus.fwd_data !== exp_fd || bus.ld_hazard !== exp_hz) begin
            errors++;
            $display("FAIL fwd_word: got hit=%b data=%h hz=%b expected %b %h %b", bus.fwd_hit, bus.fwd_data, bus.ld_hazard, exp_hit, exp_fd, exp_hz);
        end
        bus.ld_addr = 32'h104;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0 || bus.ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL fwd_miss: got hit=%b hz=%b expected 0 0", bus.fwd_hit, bus.ld_hazard);
        end
        bus.ld_req = 1'b0;
        put(2'b01, 32'h101, 32'h55);
        step();
        idle();
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h100;
        #1;
        checks++;
        if (bus.fwd_hit !== 1'b0 || bus.ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL fwd_young_byte: got hit=%b hz=%b expected 0 1", bus.fwd_hit, bus.ld_hazard);
        end
        bus.ld_req = 1'b0;
        put(2'b11, 32'h100, 32'hCAFEF00D);
        step();
        idle();
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h103;
        #1;
`ifdef STORE_BUF_FWD_EN
        exp_fd = 32'hCAFEF00D;
`endif
        checks++;
        if (bus.fwd_hit !== exp_hit || bus.fwd_data !== exp_fd || bus.ld_hazard !== exp_hz) begin
            errors++;
            $display("FAIL fwd_young_word: got hit=%b data=%h hz=%b expected %b %h %b", bus.fwd_hit, bus.fwd_data, bus.ld_hazard, exp_hit, exp_fd, exp_hz);
        end
        drain_all();
    endtask

    task automatic test_byte_hazard();
        idle();
        bus.mem_ready = 1'b0;
        put(2'b01, 32'h200, 32'h7F);
        step();
        idle();
        bus.ld_req  = 1'b1;
        bus.ld_addr = 32'h200;
        #1;
        checks++;
        if (bus.ld_hazard !== 1'b1 || bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL byte_hz: got hz=%b hit=%b expected 1 0", bus.ld_hazard, bus.fwd_hit);
        end
        step();
        checks++;
        if (bus.ld_hazard !== 1'b1) begin errors++; $display("FAIL byte_hz_hold: got %b expected 1", bus.ld_hazard); end
        bus.mem_ready = 1'b1;
        step();
        checks++;
        if (bus.ld_hazard !== 1'b0) begin errors++; $display("FAIL byte_hz_clear: got %b expected 0", bus.ld_hazard); end
        bus.mem_ready = 1'b0;
        bus.ld_addr   = 32'h300;
        put(2'b11, 32'h300, 32'h0BADF00D);
        #1;
        checks++;
        if (bus.ld_hazard !== 1'b0 || bus.fwd_hit !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle: got hz=%b hit=%b expected 0 0", bus.ld_hazard, bus.fwd_hit);
        end
        step();
        bus.st_size = 2'b00;
        #1;
        checks++;
`ifdef STORE_BUF_FWD_EN
        if (bus.fwd_hit !== 1'b1 || bus.fwd_data !== 32'h0BADF00D || bus.ld_hazard !== 1'b0) begin
            errors++;
            $display("FAIL next_cycle: got hit=%b data=%h hz=%b expected 1 0badf00d 0", bus.fwd_hit, bus.fwd_data, bus.ld_hazard);
        end
`else
        if (bus.fwd_hit !== 1'b0 || bus.ld_hazard !== 1'b1) begin
            errors++;
            $display("FAIL next_cycle: got hit=%b hz=%b expected 0 1", bus.fwd_hit, bus.ld_hazard);
        end
`endif
        drain_all();
    endtask

    task automatic test_back_to_back();
        idle();
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            put(2'(i % 3 + 1), 32'h800 + 32'(4 * i), $urandom);
            #1;
            checks++;
            if (bus.stall !== 1'b0) begin errors++; $display("FAIL b2b_stall_%0d: got %b expected 0", i, bus.stall); end
            step();
        end
        drain_all();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            put(2'b11, 32'h900 + 32'(4 * i), 32'hD0 + 32'(i));
            step();
        end
        idle();
        #2;
        reset = 1'b0;
        #1;
        checks++; if (count !== 0)          begin errors++; $display("FAIL mid_count: got %0d expected 0", count); end
        checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL mid_empty: got %b expected 1", empty); end
        checks++; if (bus.mem_we !== 2'b00 || bus.mem_addr !== 0 || bus.mem_wdata !== 0) begin
            errors++;
            $display("FAIL mid_mem: got we=%b addr=%h data=%h expected 00 0 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        sb.delete();
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.mem_ready = 1'b1;
        repeat (3) step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_latency();
        test_full_stall();
        test_misalign();
        test_forward();
        test_byte_hazard();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer between the pipeline's MEM stage and data memory. It accepts stores from the MEM stage's `memwrite`/`dataadr`/`writedata` outputs in one cycle and drains them in order to a memory port that may take several cycles. It stalls the pipeline only when full, and flags loads that hit a pending store.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; must be a power of two, at least 2.
- `AW`, 32: address width.
- `DW`, 32: data width.

Ports:
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `st_size`  in  2  store request, same encoding as `memwrite`: 00 none, 01 byte, 10 halfword, 11 word.
- `st_addr`  in  AW  store byte address.
- `st_data`  in  DW  store data, right-aligned.
- `stall`  out  1  MEM stage must hold its current store.
- `misalign`  out  1  one-cycle pulse: the offered store was misaligned and dropped.
- `mem_we`  out  2  head entry size; 00 when the buffer is empty.
- `mem_addr`  out  AW  head entry address.
- `mem_wdata`  out  DW  head entry data.
- `mem_ready`  in  1  memory accepts the head entry this cycle.
- `empty`  out  1  no pending entries.
- `count`  out  $clog2(DEPTH+1)  number of occupied entries.
- `ld_req`  in  1  MEM stage is issuing a load.
- `ld_addr`  in  AW  load byte address.
- `ld_hazard`  out  1  the load must stall until the buffer drains past the matching entry.
- `fwd_hit`  out  1  the load is satisfied from the buffer.
- `fwd_data`  out  DW  forwarded word.

## Operation
- Circular FIFO with head and tail pointers plus a count. Occupancy states:
  - EMPTY: count 0.
  - PARTIAL: 0 < count < DEPTH.
  - FULL: count = DEPTH.
- Offer: `st_size` != 00. Alignment rules:
  - Halfword requires `st_addr[0]` = 0.
  - Word requires `st_addr[1:0]` = 0.
  - A misaligned offer is not enqueued and pulses `misalign`. It never stalls.
- Drain: occurs on a cycle with `mem_we` != 00 and `mem_ready` = 1. The head pointer advances.
- Enqueue: an aligned offer is written at the tail when the buffer is not FULL, or when it is FULL and a drain occurs in the same cycle.
- `stall` = FULL and aligned offer and no drain in that cycle. `stall` is combinational.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Load match: a valid entry matches when `st_addr[AW-1:2]` = `ld_addr[AW-1:2]`.
  - `ld_hazard` = `ld_req` and any match and not `fwd_hit`.
  - Matching compares against registered entries only. A store being enqueued in the same cycle is not matched.
- `mem_wdata` carries right-aligned data. Byte-lane steering is done by memory.

## Timing
- Reset (asynchronous, `reset` = 0):
  - count = 0, pointers = 0, `empty` = 1.
  - `mem_we` = 00, `mem_addr` = 0, `mem_wdata` = 0.
  - `stall`, `misalign`, `ld_hazard`, `fwd_hit` = 0; `fwd_data` = 0.
- Reset mid-operation discards all pending stores.
- Latency: a store offered to an EMPTY buffer appears on `mem_*` in the next cycle.
- Throughput: one drain per cycle when `mem_ready` is held high.
- `mem_*` outputs hold stable while `mem_ready` = 0.
- `misalign` asserts in the offer cycle and is combinational.

## Configuration
- `STORE_BUF_FWD_EN` defined:
  - If the youngest matching entry is a word store, `fwd_hit` = `ld_req` and `fwd_data` = that entry's data, and `ld_hazard` = 0.
  - Byte or halfword youngest matches still raise `ld_hazard`.
- `STORE_BUF_FWD_EN` not defined: `fwd_hit` and `fwd_data` are tied to 0, and every match raises `ld_hazard`.

## Structure
- Package `mips_mem_pkg` holds:
  - the `mem_size_t` enum (NONE/BYTE/HALF/WORD);
  - the `sb_entry_t` struct (size, addr, data);
  - the alignment-check function.
- Sub-module `store_buffer_match` holds the per-entry word-address compare and the youngest-match priority select (age-ordered from the tail), and produces the hit vector and the forwarded data.

## Test plan
- Reset, then a word store to addr 88 with data 0 → next cycle `mem_we` = 11, `mem_addr` = 88, `mem_wdata` = 0; with `mem_ready` = 1, `empty` = 1 the cycle after.
- Hold `mem_ready` = 0 and offer 5 word stores (DEPTH 4) → `count` = 4; `stall` asserts on the 5th; raise `mem_ready` → 5th enqueues in the same cycle, `stall` drops, count stays 4.
- Halfword store to addr 0x41 → `misalign` pulses, `count` unchanged, `stall` = 0.
- Buffer holds word 0x12345678 @ 0x100, then `ld_req` with `ld_addr` 0x102 → macro defined: `fwd_hit` = 1, `fwd_data` = 0x12345678; macro undefined: `ld_hazard` = 1.
- Byte store @ 0x200, then a load from 0x200 → `ld_hazard` = 1 in both builds until that entry drains.
- Three entries pending, `reset` pulled low between clock edges → outputs clear immediately, `count` = 0, no further `mem_we`.
